music_sequencer: RTL and testbench
==================================

# music_sequencer

Beat sequencer and arbiter for the game's music path. Paces a background tune (BGM) and a one-shot event jingle (e.g. the no-score tune) by driving the beat counters of their note ROMs. It selects which ROM's 5-bit note code reaches the tone generator. The jingle pre-empts the BGM; the BGM pauses and then continues once the jingle finishes.

## Interface
Parameters:
- BEAT_DIV, 25_000_000: clock cycles per beat; must be ≥ 2.
- BGM_LEN, 64: number of beats in the BGM tune; must be ≥ 1.
- JINGLE_LEN, 9: number of beats in the jingle (beats 0..JINGLE_LEN-1); must be ≥ 1.

Ports:
- clk  in  1: system clock; single clock domain.
- rst  in  1: synchronous, active-high reset.
- bgm_en  in  1: level; BGM plays while high.
- jingle_req  in  1: single-cycle pulse that starts the jingle.
- bgm_note  in  5: note code returned by the BGM ROM for bgm_beat.
- jingle_note  in  5: note code returned by the jingle ROM for jingle_beat.
- bgm_beat  out  32: beat index sent to the BGM ROM.
- jingle_beat  out  32: beat index sent to the jingle ROM.
- note  out  5: selected note code sent to the tone generator; 0 means silence.
- jingle_busy  out  1: high while in the JINGLE state.
- jingle_done  out  1: one-cycle pulse when the jingle completes.

## Operation
- States: IDLE, BGM, JINGLE. Reset enters IDLE.
- Tick counter tick_cnt counts 0..BEAT_DIV-1. beat_tick is asserted when tick_cnt == BEAT_DIV-1; tick_cnt then returns to 0.
- tick_cnt is cleared on every state transition, so each beat in the new state lasts a full BEAT_DIV cycles.
- From IDLE:
  - jingle_req → JINGLE with jingle_beat = 0.
  - Otherwise, bgm_en → BGM.
  - jingle_req has priority when both are high.
- In BGM:
  - On beat_tick, bgm_beat increments. After BGM_LEN-1 it wraps to 0.
  - jingle_req → JINGLE with jingle_beat = 0; bgm_beat holds its value.
  - bgm_en low (and no jingle_req) → IDLE with bgm_beat = 0.
- In JINGLE:
  - On beat_tick, jingle_beat increments.
  - On beat_tick with jingle_beat == JINGLE_LEN-1: jingle_done pulses and jingle_beat returns to 0. Next state is BGM if bgm_en is high, else IDLE with bgm_beat cleared.
  - jingle_req while in JINGLE is ignored, except in the final-beat tick cycle. There it restarts the jingle: stay in JINGLE, jingle_beat = 0, jingle_done still pulses.
  - bgm_en changes during JINGLE take effect only when the jingle ends.
- note is registered from the current state's source: 0 in IDLE, bgm_note in BGM, jingle_note in JINGLE.
- jingle_busy is high exactly while the state is JINGLE.

## Timing
- Reset values: state IDLE, tick_cnt 0, bgm_beat 0, jingle_beat 0, note 0, jingle_busy 0, jingle_done 0.
- Reset asserted mid-operation returns the block to these values on the next clock edge, with no partial completion and no jingle_done pulse.
- Beat outputs and jingle_busy are registered; they change on the edge that follows the triggering condition.
- The ROMs are combinational. note lags a beat-index change by exactly 1 cycle, and lags a state change by 1 cycle.
- Latency from jingle_req to jingle_busy = 1 cycle. Latency from jingle_req to the first jingle note on note = 2 cycles.
- A jingle lasts JINGLE_LEN × BEAT_DIV cycles. jingle_done is asserted on the cycle after the final beat_tick, coincident with jingle_busy falling.

## Configuration
- MUSIC_BGM_RESUME_EN:
  - Defined: after a jingle, the BGM resumes at the bgm_beat value held when it was pre-empted.
  - Undefined: bgm_beat is cleared to 0 on entry to JINGLE, so the BGM restarts from its first beat after the jingle.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use BEAT_DIV=4, BGM_LEN=8, JINGLE_LEN=9, ROMs modelled as note = beat[4:0] + 1.
- Reset, then bgm_en=1 held → bgm_beat steps 0,1,..,7,0 every 4 cycles; note = bgm_beat+1 one cycle later; wrap 7→0 is seen.
- BGM at bgm_beat=5, pulse jingle_req → jingle_busy=1 next cycle; jingle_beat steps 0..8 over 36 cycles; jingle_done pulses once; BGM continues at 5 (MUSIC_BGM_RESUME_EN defined) or at 0 (undefined).
- IDLE, jingle_req with bgm_en=0 → jingle plays; after jingle_done the block returns to IDLE and note=0.
- jingle_req at jingle_beat=3 → ignored, no restart. jingle_req in the final-tick cycle → jingle_done pulses, jingle_beat=0, jingle_busy stays 1.
- bgm_en dropped at bgm_beat=4 → IDLE next cycle, bgm_beat=0, note=0 one cycle later.
- rst asserted at jingle_beat=6 → next cycle all outputs are at their reset values and no jingle_done pulse occurs.

Source files
------------

// File: rtl/music_sequencer_if.sv
// -----------------------------------------------------------------------------
// music_sequencer_if
// Bundles the note-ROM and control signals of the music sequencer.
//   bgm_en       level, BGM plays while high              (master -> slave)
//   jingle_req   one-cycle pulse starting the jingle      (master -> slave)
//   bgm_note     BGM ROM note code for bgm_beat            (master -> slave)
//   jingle_note  jingle ROM note code for jingle_beat      (master -> slave)
//   bgm_beat     beat index to the BGM ROM                 (slave -> master)
//   jingle_beat  beat index to the jingle ROM              (slave -> master)
//   note         selected note code, 0 = silence           (slave -> master)
//   jingle_busy  high while the jingle is playing          (slave -> master)
//   jingle_done  one-cycle pulse when the jingle completes (slave -> master)
// -----------------------------------------------------------------------------
interface music_sequencer_if;
    logic        bgm_en;
    logic        jingle_req;
    logic [4:0]  bgm_note;
    logic [4:0]  jingle_note;
    logic [31:0] bgm_beat;
    logic [31:0] jingle_beat;
    logic [4:0]  note;
    logic        jingle_busy;
    logic        jingle_done;

    modport master (
        output bgm_en, jingle_req, bgm_note, jingle_note,
        input  bgm_beat, jingle_beat, note, jingle_busy, jingle_done
    );

    modport slave (
        input  bgm_en, jingle_req, bgm_note, jingle_note,
        output bgm_beat, jingle_beat, note, jingle_busy, jingle_done
    );
endinterface

// File: rtl/music_sequencer.sv
// -----------------------------------------------------------------------------
// music_sequencer
// Beat sequencer and arbiter for the music path. Paces a looping background
// tune (BGM) and a one-shot jingle by driving the beat indices of their note
// ROMs, and forwards the active ROM's note code to the tone generator. The
// jingle pre-empts the BGM; the BGM continues once the jingle ends.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   music_sequencer_if.slave (bgm_en, jingle_req, bgm_note, jingle_note
//         in; bgm_beat, jingle_beat, note, jingle_busy, jingle_done out)
//
// Parameters:
//   BEAT_DIV    clock cycles per beat (>= 2)
//   BGM_LEN     beats in the BGM tune (>= 1)
//   JINGLE_LEN  beats in the jingle (>= 1)
//
// Build option:
//   MUSIC_BGM_RESUME_EN  defined: the BGM resumes at the beat where the
//                        jingle pre-empted it. Undefined: the BGM restarts
//                        from beat 0 after the jingle.
// -----------------------------------------------------------------------------
module music_sequencer #(
    parameter int BEAT_DIV   = 25_000_000,
    parameter int BGM_LEN    = 64,
    parameter int JINGLE_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    music_sequencer_if.slave  bus
);

    localparam int                 TICK_W      = $clog2(BEAT_DIV);
    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(BEAT_DIV - 1);
    localparam logic [31:0]        BGM_LAST    = 32'(BGM_LEN - 1);
    localparam logic [31:0]        JINGLE_LAST = 32'(JINGLE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BGM,
        S_JINGLE
    } state_t;

    state_t             state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [31:0]        bgm_beat;
    logic [31:0]        jingle_beat;
    logic [4:0]         note;
    logic               jingle_busy;
    logic               jingle_done;
    logic               beat_tick;

    assign beat_tick = (tick_cnt == TICK_LAST);

    // Next BGM beat with wrap back to the start of the tune.
    function automatic logic [31:0] bgm_advance(input logic [31:0] beat);
        return (beat == BGM_LAST) ? 32'd0 : beat + 32'd1;
    endfunction

    // Tick counter step: wraps at the end of a beat.
    function automatic logic [TICK_W-1:0] tick_advance(input logic [TICK_W-1:0] cnt,
                                                       input logic tick);
        return tick ? '0 : cnt + TICK_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bgm_beat    <= '0;
            jingle_beat <= '0;
            note        <= '0;
            jingle_busy <= 1'b0;
            jingle_done <= 1'b0;
        end else begin
            jingle_done <= 1'b0;

            // note follows the source of the state we are in now, so it lags
            // any beat or state change by exactly one cycle.
            unique case (state)
                S_BGM:    note <= bus.bgm_note;
                S_JINGLE: note <= bus.jingle_note;
                default:  note <= '0;
            endcase

            unique case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (bus.jingle_req) begin
                        state       <= S_JINGLE;
                        jingle_busy <= 1'b1;
                        jingle_beat <= '0;
                    end else if (bus.bgm_en) begin
                        state <= S_BGM;
                    end
                end

                S_BGM: begin
                    if (bus.jingle_req) begin
                        // Pre-emption wins over a coincident beat tick.
                        state       <= S_JINGLE;
                        jingle_busy <= 1'b1;
                        jingle_beat <= '0;
                        tick_cnt    <= '0;
`ifndef MUSIC_BGM_RESUME_EN
                        bgm_beat    <= '0;
`endif
                    end else if (!bus.bgm_en) begin
                        state    <= S_IDLE;
                        bgm_beat <= '0;
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_advance(tick_cnt, beat_tick);
                        if (beat_tick) begin
                            bgm_beat <= bgm_advance(bgm_beat);
                        end
                    end
                end

                S_JINGLE: begin
                    tick_cnt <= tick_advance(tick_cnt, beat_tick);
                    if (beat_tick) begin
                        if (jingle_beat == JINGLE_LAST) begin
                            jingle_done <= 1'b1;
                            jingle_beat <= '0;
                            // A request landing on the final tick restarts
                            // the jingle; anywhere else it is ignored.
                            if (bus.jingle_req) begin
                                state <= S_JINGLE;
                            end else if (bus.bgm_en) begin
                                state       <= S_BGM;
                                jingle_busy <= 1'b0;
                            end else begin
                                state       <= S_IDLE;
                                jingle_busy <= 1'b0;
                                bgm_beat    <= '0;
                            end
                        end else begin
                            jingle_beat <= jingle_beat + 32'd1;
                        end
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    jingle_busy <= 1'b0;
                    tick_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.bgm_beat    = bgm_beat;
    assign bus.jingle_beat = jingle_beat;
    assign bus.note        = note;
    assign bus.jingle_busy = jingle_busy;
    assign bus.jingle_done = jingle_done;

endmodule

// File: tb/tb_music_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_sequencer
// Self-checking bench for music_sequencer with BEAT_DIV=4, BGM_LEN=8,
// JINGLE_LEN=9 and ROMs modelled as note = beat[4:0] + 1. A behavioural model
// tracks the current activity and the cycles spent in it, deriving beat
// indices arithmetically; directed scenarios pin key literal values, then a
// randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_music_sequencer;

    localparam int BD = 4;
    localparam int BL = 8;
    localparam int JL = 9;

`ifdef MUSIC_BGM_RESUME_EN
    localparam bit RESUME = 1'b1;
`else
    localparam bit RESUME = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    music_sequencer_if bus();

    music_sequencer #(
        .BEAT_DIV   (BD),
        .BGM_LEN    (BL),
        .JINGLE_LEN (JL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational ROM models.
    assign bus.bgm_note    = bus.bgm_beat[4:0] + 5'd1;
    assign bus.jingle_note = bus.jingle_beat[4:0] + 5'd1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Activity: 0 silent, 1 playing BGM, 2 playing jingle.
    int m_mode      = 0;
    int m_elapsed   = 0;   // cycles since entering the current activity
    int m_bgm_start = 0;   // BGM position at the moment the BGM (re)started
    int m_held      = 0;   // BGM position shown while the jingle plays
    logic [4:0] exp_note = '0;
    logic       exp_done = 1'b0;

    function automatic int bgm_pos();
        if (m_mode == 1) return (m_bgm_start + m_elapsed / BD) % BL;
        if (m_mode == 2) return m_held;
        return 0;
    endfunction

    function automatic int jingle_pos();
        return (m_mode == 2) ? m_elapsed / BD : 0;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_elapsed = 0; m_bgm_start = 0; m_held = 0;
            exp_note = '0; exp_done = 1'b0;
        end else begin
            if (m_mode == 0)      exp_note = '0;
            else if (m_mode == 1) exp_note = 5'(bgm_pos() + 1);
            else                  exp_note = 5'(jingle_pos() + 1);
            exp_done = 1'b0;
            case (m_mode)
                0: begin
                    if (bus.jingle_req) begin
                        m_mode = 2; m_elapsed = 0; m_held = 0;
                    end else if (bus.bgm_en) begin
                        m_mode = 1; m_elapsed = 0; m_bgm_start = 0;
                    end
                end
                1: begin
                    if (bus.jingle_req) begin
                        m_held = RESUME ? bgm_pos() : 0;
                        m_mode = 2; m_elapsed = 0;
                    end else if (!bus.bgm_en) begin
                        m_mode = 0; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
                default: begin
                    if (m_elapsed == JL * BD - 1) begin
                        exp_done = 1'b1;
                        m_elapsed = 0;
                        if (bus.jingle_req) begin
                            m_mode = 2;
                        end else if (bus.bgm_en) begin
                            m_mode = 1; m_bgm_start = m_held;
                        end else begin
                            m_mode = 0; m_held = 0;
                        end
                    end else begin
                        m_elapsed++;
                    end
                end
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("bgm_beat",    bus.bgm_beat,    32'(bgm_pos()));
            check("jingle_beat", bus.jingle_beat, 32'(jingle_pos()));
            check("note",        32'(bus.note),   32'(exp_note));
            check("jingle_busy", 32'(bus.jingle_busy), 32'(m_mode == 2));
            check("jingle_done", 32'(bus.jingle_done), 32'(exp_done));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.bgm_en     = 1'b0;
        bus.jingle_req = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset values.
        check("rst_bgm_beat", bus.bgm_beat, 32'd0);
        check("rst_jbeat",    bus.jingle_beat, 32'd0);
        check("rst_note",     32'(bus.note), 32'd0);
        check("rst_busy",     32'(bus.jingle_busy), 32'd0);

        // BGM playback: 20 cycles after entry -> beat 5, note shows beat 4 + 1.
        bus.bgm_en = 1'b1;
        cyc();
        cycles(20);
        check("bgm_beat_at_20", bus.bgm_beat, 32'd5);
        check("bgm_note_at_20", 32'(bus.note), 32'd5);

        // Pre-empt at beat 5.
        bus.jingle_req = 1'b1;
        cyc();
        bus.jingle_req = 1'b0;
        check("preempt_busy", 32'(bus.jingle_busy), 32'd1);
        check("preempt_jbeat", bus.jingle_beat, 32'd0);
        check("preempt_bgm_beat", bus.bgm_beat, RESUME ? 32'd5 : 32'd0);
        cyc();
        check("first_jingle_note", 32'(bus.note), 32'd1);
        cycles(34);
        check("last_jbeat", bus.jingle_beat, 32'd8);
        check("last_beat_busy", 32'(bus.jingle_busy), 32'd1);
        cyc();
        check("jingle_done_pulse", 32'(bus.jingle_done), 32'd1);
        check("busy_falls", 32'(bus.jingle_busy), 32'd0);
        check("bgm_resume_beat", bus.bgm_beat, RESUME ? 32'd5 : 32'd0);
        cyc();
        check("done_one_cycle", 32'(bus.jingle_done), 32'd0);

        // BGM continues, then bgm_en drops.
        cycles(10);
        bus.bgm_en = 1'b0;
        cyc();
        check("drop_bgm_beat", bus.bgm_beat, 32'd0);
        cyc();
        check("drop_note", 32'(bus.note), 32'd0);

        // Jingle from IDLE, returns to IDLE.
        bus.jingle_req = 1'b1;
        cyc();
        bus.jingle_req = 1'b0;
        cycles(35);
        cyc();
        check("idle_jingle_done", 32'(bus.jingle_done), 32'd1);
        check("idle_jingle_busy", 32'(bus.jingle_busy), 32'd0);
        cyc();
        check("idle_note_after", 32'(bus.note), 32'd0);

        // Ignored mid-jingle request, then restart on the final tick.
        bus.jingle_req = 1'b1;
        cyc();
        bus.jingle_req = 1'b0;
        cycles(12);
        bus.jingle_req = 1'b1;
        cyc();
        bus.jingle_req = 1'b0;
        check("ignored_req_jbeat", bus.jingle_beat, 32'd3);
        cycles(22);
        bus.jingle_req = 1'b1;
        cyc();
        bus.jingle_req = 1'b0;
        check("restart_done", 32'(bus.jingle_done), 32'd1);
        check("restart_busy", 32'(bus.jingle_busy), 32'd1);
        check("restart_jbeat", bus.jingle_beat, 32'd0);
        cycles(35);
        cyc();
        check("restart_end_done", 32'(bus.jingle_done), 32'd1);

        // Reset in the middle of a jingle.
        bus.jingle_req = 1'b1;
        cyc();
        bus.jingle_req = 1'b0;
        cycles(24);
        check("pre_rst_jbeat", bus.jingle_beat, 32'd6);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_jbeat", bus.jingle_beat, 32'd0);
        check("mid_rst_busy",  32'(bus.jingle_busy), 32'd0);
        check("mid_rst_done",  32'(bus.jingle_done), 32'd0);
        check("mid_rst_note",  32'(bus.note), 32'd0);

        // Randomized phase against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.bgm_en = ~bus.bgm_en;
            bus.jingle_req = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        bus.jingle_req = 1'b0;
        rst = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
